fifo_wr_ctrl: RTL

Write-side controller of the asynchronous FIFO, running in the write clock domain and sitting directly upstream of the dual-port storage RAM. It accepts write requests, drives the RAM write enable and write address, and keeps a binary and Gray-coded write pointer. It synchronizes the read-domain Gray pointer into CLK and produces registered FULL, ALMOST_FULL and fill-level status.

---
 rtl/fifo_wr_ctrl_if.sv | 40 ++++
 rtl/fifo_wr_ctrl.sv | 100 ++++++++++
 2 files changed

// File: rtl/fifo_wr_ctrl_if.sv
// Write-side bus of the asynchronous FIFO.
// The master side is the producer plus the read-domain pointer source.
// The slave side is the write controller that answers them.
interface fifo_wr_ctrl_if #(
    parameter int ADDR_WIDTH = 4
);
    logic                  WR_REQ;
    logic [ADDR_WIDTH:0]   RD_PTR_GRAY;
    logic                  WEN;
    logic [ADDR_WIDTH-1:0] WR_ADDR;
    logic [ADDR_WIDTH:0]   WR_PTR_GRAY;
    logic                  FULL;
    logic                  ALMOST_FULL;
    logic [ADDR_WIDTH:0]   WR_LEVEL;
    logic                  OVERFLOW;

    modport master (
        output WR_REQ,
        output RD_PTR_GRAY,
        input  WEN,
        input  WR_ADDR,
        input  WR_PTR_GRAY,
        input  FULL,
        input  ALMOST_FULL,
        input  WR_LEVEL,
        input  OVERFLOW
    );

    modport slave (
        input  WR_REQ,
        input  RD_PTR_GRAY,
        output WEN,
        output WR_ADDR,
        output WR_PTR_GRAY,
        output FULL,
        output ALMOST_FULL,
        output WR_LEVEL,
        output OVERFLOW
    );
endinterface

// File: rtl/fifo_wr_ctrl.sv
// Write-domain controller of the asynchronous FIFO.
// It owns the binary/Gray write pointer and drives the RAM write port.
// It synchronizes the read Gray pointer into this clock domain.
// It produces pessimistic registered FULL, ALMOST_FULL, level and overflow status.
module fifo_wr_ctrl #(
    parameter int ADDR_WIDTH   = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int AFULL_THRESH = 2**ADDR_WIDTH - 2
) (
    input  logic           CLK,
    input  logic           RST,
    fifo_wr_ctrl_if.slave  bus
);
    localparam int AW = ADDR_WIDTH;
    localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);
    localparam logic [AW:0] AFULL_LVL = AFULL_THRESH[AW:0];

    logic [AW:0] wbin;
    logic [AW:0] wr_ptr_gray_q;
    logic        full_q;
    logic        afull_q;
    logic [AW:0] level_q;
    logic        overflow_q;
    logic [AW:0] sync_q [SYNC_STAGES];

    logic        wen;
    logic [AW:0] wbin_next;
    logic [AW:0] gray_next;
    logic [AW:0] rq_sync;
    logic [AW:0] rbin_sync;
    logic        full_next;
    logic [AW:0] lvl_next;
    logic        afull_next;

    function automatic logic [AW:0] gray_to_bin(input logic [AW:0] g);
        logic [AW:0] b;
        b = g;
        for (int i = AW - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Next-pointer and status arithmetic. FULL compares the next Gray
    // pointer against the synchronized read pointer with its top two bits
    // inverted. That is the Gray form of "same address, opposite wrap".
    always_comb begin
        wen        = bus.WR_REQ & ~full_q;
        wbin_next  = wen ? (wbin + PTR_ONE) : wbin;
        gray_next  = (wbin_next >> 1) ^ wbin_next;
        rq_sync    = sync_q[SYNC_STAGES-1];
        rbin_sync  = gray_to_bin(rq_sync);
        full_next  = (gray_next == {~rq_sync[AW:AW-1], rq_sync[AW-2:0]});
        lvl_next   = wbin_next - rbin_sync;
        afull_next = (lvl_next >= AFULL_LVL);
    end

    // Read-pointer synchronizer. The chain holds only Gray values, so a
    // pointer caught mid-change resolves to either its old value or its new one.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= bus.RD_PTR_GRAY;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Write pointers and status registers. A write into a full FIFO is
    // dropped, and the rejected cycle produces a one-cycle OVERFLOW pulse.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wbin          <= '0;
            wr_ptr_gray_q <= '0;
            full_q        <= 1'b0;
            afull_q       <= 1'b0;
            level_q       <= '0;
            overflow_q    <= 1'b0;
        end else begin
            wbin          <= wbin_next;
            wr_ptr_gray_q <= gray_next;
            full_q        <= full_next;
            afull_q       <= afull_next;
            level_q       <= lvl_next;
            overflow_q    <= bus.WR_REQ & full_q;
        end
    end

    assign bus.WEN         = wen;
    assign bus.WR_ADDR     = wbin[AW-1:0];
    assign bus.WR_PTR_GRAY = wr_ptr_gray_q;
    assign bus.FULL        = full_q;
    assign bus.ALMOST_FULL = afull_q;
    assign bus.WR_LEVEL    = level_q;
    assign bus.OVERFLOW    = overflow_q;
endmodule
